// File: rtl/l2_adaptor_pkg.sv
// Shared types and constants for the L2 line-to-burst memory adaptor.
package l2_adaptor_pkg;

  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int S_OFFSET = 5;
  localparam int BEATS    = S_LINE / S_BURST;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] beat_idx_t;

  // Bit position of a beat inside a cache line.
  function automatic int beat_base(input beat_idx_t k);
    return int'(k) * S_BURST;
  endfunction

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Serves whole-line L2 read/write requests as 4-beat bursts on the memory port.
// Every output is a flop; none depends combinationally on an input.
module l2_cacheline_adaptor
  import l2_adaptor_pkg::*;
#(
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST,
  parameter int s_offset = S_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam beat_idx_t last_beat = beat_idx_t'(beats - 1);
  localparam logic [31:0] offset_mask = (32'd1 << s_offset) - 32'd1;

  state_e             state_q, state_d;
  beat_idx_t          cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [s_line-1:0]  wbuf_q, wbuf_d;
  logic [s_line-1:0]  line_q, line_d;
  logic [s_burst-1:0] burst_q, burst_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;

  // Next-state, beat counter and data-path register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
          cnt_d   = 2'd0;
          addr_d  = address_i & ~offset_mask;
        end else if (write_i) begin
          state_d = WRITE;
          cnt_d   = 2'd0;
          addr_d  = address_i & ~offset_mask;
          wbuf_d  = line_i;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[beat_base(cnt_q) +: s_burst] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_beat) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_beat) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they appear registered.
  always_comb begin
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    if (state_d == WRITE) begin
      burst_d = wbuf_d[beat_base(cnt_d) +: s_burst];
    end else begin
      burst_d = burst_q;
    end
  end

  // State and output registers; reset discards any partial transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wbuf_q  <= '0;
      line_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed self-checking bench for l2_cacheline_adaptor.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total = 0;
  int bad = 0;
  int resp_cnt = 0;
  logic illegal_seen = 1'b0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  // Counts resp_o pulses and flags simultaneous read/write requests.
  always @(posedge clk) begin
    if (resp_o) resp_cnt <= resp_cnt + 1;
    if (!rst && read_i && write_i && !illegal_seen) begin
      $display("protocol: read_i and write_i asserted together at %0t", $time);
      illegal_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a read of four back-to-back beats and checks the assembled line.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] b0,
                         input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] beats_v [4];
    beats_v[0] = b0; beats_v[1] = b1; beats_v[2] = b2; beats_v[3] = b3;
    address_i = addr;
    read_i = 1'b1;
    tick();
    check({tag, "_read_o"}, 256'(read_o), 256'(1'b1));
    check({tag, "_addr"}, 256'(address_o), 256'({addr[31:5], 5'd0}));
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = beats_v[i];
      check({tag, "_no_early_resp"}, 256'(resp_o), 256'(1'b0));
      tick();
    end
    resp_i = 1'b0;
    check({tag, "_resp"}, 256'(resp_o), 256'(1'b1));
    check({tag, "_read_drop"}, 256'(read_o), 256'(1'b0));
    check({tag, "_line"}, line_o, {b3, b2, b1, b0});
    tick();
    read_i = 1'b0;
    check({tag, "_resp_once"}, 256'(resp_o), 256'(1'b0));
  endtask

  logic [63:0] d0, d1, d2, d3;
  logic [255:0] rline;
  logic [6:0] wpat;
  logic [63:0] wexp [7];
  int cnt_before;

  initial begin
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #12;
    check("rst_read_o", 256'(read_o), 256'(1'b0));
    check("rst_write_o", 256'(write_o), 256'(1'b0));
    check("rst_resp_o", 256'(resp_o), 256'(1'b0));
    check("rst_addr", 256'(address_o), 256'(32'd0));
    check("rst_line", line_o, 256'd0);
    check("rst_burst", 256'(burst_o), 256'(64'd0));
    rst = 1'b0;
    tick();

    // Read with consecutive beats
    do_read("rd1", 32'h1234_5678, 64'h0, 64'h1111_1111_1111_1111,
            64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333);
    rline = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0};
    check("rd1_addr_exact", 256'(address_o), 256'(32'h1234_5660));

    // Back-to-back: write request the cycle after read_i drops
    tick();
    check("b2b_no_spurious_read", 256'(read_o), 256'(1'b0));
    d0 = 64'hD0D0_0000_0000_0001; d1 = 64'hD1D1_0000_0000_0002;
    d2 = 64'hD2D2_0000_0000_0003; d3 = 64'hD3D3_0000_0000_0004;
    line_i = {d3, d2, d1, d0};
    address_i = 32'h8000_003F;
    write_i = 1'b1;
    tick();
    check("wr_write_o", 256'(write_o), 256'(1'b1));
    check("wr_read_o", 256'(read_o), 256'(1'b0));
    check("wr_addr", 256'(address_o), 256'(32'h8000_0020));
    check("wr_line_kept", line_o, rline);
    wpat = 7'b1011001;
    wexp[0] = d0; wexp[1] = d1; wexp[2] = d1; wexp[3] = d1;
    wexp[4] = d2; wexp[5] = d3; wexp[6] = d3;
    for (int i = 0; i < 7; i++) begin
      resp_i = wpat[i];
      check($sformatf("wr_burst%0d", i), 256'(burst_o), 256'(wexp[i]));
      check($sformatf("wr_hold%0d", i), 256'(write_o), 256'(1'b1));
      check($sformatf("wr_noresp%0d", i), 256'(resp_o), 256'(1'b0));
      tick();
    end
    resp_i = 1'b0;
    check("wr_resp", 256'(resp_o), 256'(1'b1));
    check("wr_drop", 256'(write_o), 256'(1'b0));
    tick();
    write_i = 1'b0;
    check("wr_resp_once", 256'(resp_o), 256'(1'b0));
    tick();

    // Reset in the middle of a read after two beats
    cnt_before = resp_cnt;
    address_i = 32'h0000_1000;
    read_i = 1'b1;
    tick();
    resp_i = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    tick();
    resp_i = 1'b0;
    read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_read_o", 256'(read_o), 256'(1'b0));
    check("mid_rst_resp_o", 256'(resp_o), 256'(1'b0));
    check("mid_rst_line", line_o, 256'd0);
    #1 rst = 1'b0;
    tick();
    check("mid_rst_no_resp", 256'(resp_cnt), 256'(cnt_before));
    do_read("rd2", 32'h0000_2004, 64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555,
            64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777);
    tick();

    // Spurious resp_i while idle
    resp_i = 1'b1;
    tick();
    tick();
    check("idle_resp_read_o", 256'(read_o), 256'(1'b0));
    check("idle_resp_write_o", 256'(write_o), 256'(1'b0));
    check("idle_resp_resp_o", 256'(resp_o), 256'(1'b0));
    resp_i = 1'b0;
    check("no_flag_yet", 256'(illegal_seen), 256'(1'b0));

    // Simultaneous read and write: read wins
    write_i = 1'b1;
    line_i = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    do_read("both", 32'h0000_4000, 64'h8, 64'h9, 64'hA, 64'hB);
    write_i = 1'b0;
    check("both_write_o", 256'(write_o), 256'(1'b0));
    check("both_flagged", 256'(illegal_seen), 256'(1'b1));
    tick();
    check("resp_total", 256'(resp_cnt), 256'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
